// File: rtl/fetch_controller_pkg.sv
// Shared types and widths for the fetch controller slice.
// Optional timeout feature is enabled with FETCH_TIMEOUT_EN.
package fetch_controller_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_timeout_counter.sv
// Counts consecutive un-acked request cycles for the fetch controller.
// Only compiled and used when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // expired fires during the TIMEOUT-th un-acked cycle, so the FSM leaves REQ on that edge
    always_comb begin
        expired = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: request, capture, present, advance PC or halt.
// Define FETCH_TIMEOUT_EN to add the memory-ack timeout and sticky timeout_err.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = 16'h0000,
    parameter int unsigned       TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               hlt,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted,
    output logic               timeout_err
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
    logic timeout_clear, timeout_count;

    always_comb begin
        timeout_clear = (state_d == ST_REQ) && (state_q != ST_REQ);
        timeout_count = (state_q == ST_REQ) && !imem_ack;
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timeout_clear),
        .count_en (timeout_count),
        .expired  (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // TIMEOUT has no effect without the timeout feature; REQ waits indefinitely
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VEC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_ISSUE;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_ISSUE: begin
                // redirect outranks hlt; both are ignored while stalled
                if (!stall) begin
                    if (redirect) begin
                        pc_d    = redirect_addr;
                        state_d = ST_REQ;
                    end else if (hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_REQ);
        instr_valid = (state_q == ST_ISSUE);
        halted      = (state_q == ST_HALT);
        imem_addr   = pc_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VEC SHALL be 16'h0000: first fetch address after reset.
REQ-002 Parameter TIMEOUT SHALL be 15: max REQ cycles without ack (used only under FETCH_TIMEOUT_EN).
REQ-003 clk  in  1  clock; all state SHALL update on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  downstream not ready; holds presented instruction.
REQ-006 hlt  in  1  presented instruction is halt; sampled only when consumed.
REQ-007 redirect  in  1  branch/jump taken; redirect_addr valid.
REQ-008 redirect_addr  in  16  next fetch target.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  16  fetch address (current PC).
REQ-011 imem_ack  in  1  memory returns data this cycle.
REQ-012 imem_rdata  in  16  instruction word, valid with imem_ack.
REQ-013 instr  out  16  captured instruction.
REQ-014 instr_valid  out  1  instr/instr_pc valid.
REQ-015 instr_pc  out  16  address of instr.
REQ-016 halted  out  1  processor halted.
REQ-017 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-018 FSM SHALL have states IDLE, REQ, ISSUE, HALT, encoded as 2 bits.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to REQ with pc=RESET_VEC.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr=pc; imem_req SHALL be 0 in all other states.
REQ-021 On imem_ack in REQ: instr<=imem_rdata, instr_pc<=pc, go to ISSUE; ack outside REQ SHALL be ignored.
REQ-022 In ISSUE, instr_valid SHALL be 1; with stall=1 state, instr, instr_pc, pc SHALL hold.
REQ-023 In ISSUE with stall=0 (consume): redirect=1 -> pc<=redirect_addr, REQ; else hlt=1 -> HALT, pc holds; else pc<=pc+1, REQ.
REQ-024 redirect SHALL take priority over hlt in the same consume cycle.
REQ-025 redirect/hlt outside a consume cycle SHALL be ignored.
REQ-026 pc+1 SHALL be 16-bit modulo: 16'hFFFF wraps to 16'h0000.
REQ-027 Ack-to-instr_valid latency SHALL be one cycle; back-to-back throughput one instruction per two cycles with single-cycle ack.
REQ-028 HALT SHALL assert halted=1, instr_valid=0, and be left only by reset.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, pc=RESET_VEC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, halted=0, timeout_err=0.
REQ-030 Reset mid-REQ SHALL abandon the request; a late ack SHALL not be captured.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined: counter counts REQ cycles, cleared on entering REQ; reaching TIMEOUT without ack SHALL set timeout_err=1 and go to HALT.
REQ-032 Without FETCH_TIMEOUT_EN: no counter, timeout_err tied 0, REQ waits indefinitely.

Structure
REQ-033 Shared package SHALL hold the FSM state typedef/encodings, ADDR_W=16, INSTR_W=16.
REQ-034 Sub-module fetch_timeout_counter SHALL implement the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-035 Reset release, ack each REQ cycle, rdata=16'hA000+addr -> instr_pc 0,1,2..., instr=16'hA000,16'hA001..., valid every 2nd cycle.
REQ-036 stall=1 for 3 cycles in ISSUE at pc=5 -> instr_valid held, instr_pc=5 stable, imem_req=0.
REQ-037 Consume at pc=3 with redirect=1, redirect_addr=16'h0040, hlt=1 -> next imem_addr=16'h0040, halted=0.
REQ-038 Consume with hlt=1 at pc=7 -> halted=1 next cycle, imem_req=0 thereafter, pc=7.
REQ-039 pc=16'hFFFF consumed -> next imem_addr=16'h0000.
REQ-040 FETCH_TIMEOUT_EN, no ack for 15 REQ cycles -> timeout_err=1, halted=1; rst_n pulse clears both.
